// File: rtl/handshake_protocol_monitor.sv
// handshake_protocol_monitor
//   Passive ready/valid protocol checker for N_CH independent channels. It
//   counts transfers per channel and flags three protocol faults: valid
//   dropped before ready, payload changed while stalled, and a stall that
//   reaches MAX_STALL cycles. Error flags are sticky. The first erroring
//   channel since the last clear is also captured.
//
//   Optional build macro: HANDSHAKE_MONITOR_ASSERT_EN compiles in concurrent
//   assertions that mirror the flag checks. The flags behave the same way
//   whether or not the macro is defined.
//
// Ports
//   CLK, RESET     rising-edge clock, synchronous active-high reset
//   enable         low freezes monitoring: FSMs go idle, counts and flags hold
//   clr_err        one-cycle pulse that clears sticky errors and the capture
//   valid, ready   per-channel handshake, [N_CH]
//   data           payloads, channel i at [i*DATA_W +: DATA_W]
//   xfer_count     per-channel transfer counters, packed the same way as data
//   err_drop       sticky, valid fell before ready
//   err_data       sticky, payload changed while stalled
//   err_timeout    sticky, stall reached MAX_STALL
//   err_any        OR of all sticky error bits
//   first_err_vld  a first error is captured
//   first_err_ch   lowest channel index that raised an error at the capture edge

// Per-channel tracker: handshake FSM, stall counter, payload hold register,
// transfer counter and sticky flags. evt_any reports the errors raised at the
// current edge so the top level can do first-error capture across channels.
module hpm_lane #(
    parameter int DATA_W    = 4,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              enable,
    input  logic              clr_err,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  count,
    output logic              err_drop,
    output logic              err_data,
    output logic              err_timeout,
    output logic              evt_any
);
    // The counter needs headroom above MAX_STALL so that stall+1 cannot wrap
    // when the counter is saturated. This matters most when MAX_STALL is 1.
    localparam int ST_W = $clog2(MAX_STALL + 2);
    localparam logic [ST_W-1:0] STALL_MAX = ST_W'(MAX_STALL);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state, state_n;
    logic [ST_W-1:0]   stall, stall_n;
    logic [DATA_W-1:0] hold, hold_n;
    logic              to_done, to_done_n;
    logic              xfer, e_drop, e_data, e_to;

    always_comb begin
        state_n   = state;
        stall_n   = stall;
        hold_n    = hold;
        to_done_n = to_done;
        xfer      = 1'b0;
        e_drop    = 1'b0;
        e_data    = 1'b0;
        e_to      = 1'b0;
        if (!enable) begin
            state_n   = IDLE;
            stall_n   = '0;
            to_done_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    to_done_n = 1'b0;
                    if (valid) begin
                        if (ready) begin
                            xfer = 1'b1;
                        end else begin
                            state_n = WAIT;
                            hold_n  = data;
                            stall_n = {{(ST_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                WAIT: begin
                    if (!valid) begin
                        e_drop  = 1'b1;
                        state_n = IDLE;
                        stall_n = '0;
                    end else begin
                        if (data != hold)
                            e_data = 1'b1;
                        if (ready) begin
                            xfer    = 1'b1;
                            state_n = IDLE;
                            stall_n = '0;
                        end else begin
                            if (stall != STALL_MAX)
                                stall_n = stall + 1'b1;
                            // Raise the timeout once per wait. The edge that
                            // enters WAIT never counts toward it, so with
                            // MAX_STALL=1 the timeout fires on the second
                            // stalled cycle.
                            if (!to_done && ((stall + 1'b1) >= STALL_MAX)) begin
                                e_to      = 1'b1;
                                to_done_n = 1'b1;
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign evt_any = e_drop | e_data | e_to;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            stall       <= '0;
            hold        <= '0;
            to_done     <= 1'b0;
            count       <= '0;
            err_drop    <= 1'b0;
            err_data    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state   <= state_n;
            stall   <= stall_n;
            hold    <= hold_n;
            to_done <= to_done_n;
            if (xfer)
                count <= count + 1'b1;
            // When a clear and a new error land on the same edge, the new
            // error is kept.
            err_drop    <= (err_drop    & ~clr_err) | e_drop;
            err_data    <= (err_data    & ~clr_err) | e_data;
            err_timeout <= (err_timeout & ~clr_err) | e_to;
        end
    end
endmodule

module handshake_protocol_monitor #(
    parameter int N_CH      = 3,
    parameter int DATA_W    = 4,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 16,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     enable,
    input  logic                     clr_err,
    input  logic [N_CH-1:0]          valid,
    input  logic [N_CH-1:0]          ready,
    input  logic [N_CH*DATA_W-1:0]   data,
    output logic [N_CH*CNT_W-1:0]    xfer_count,
    output logic [N_CH-1:0]          err_drop,
    output logic [N_CH-1:0]          err_data,
    output logic [N_CH-1:0]          err_timeout,
    output logic                     err_any,
    output logic                     first_err_vld,
    output logic [CH_W-1:0]          first_err_ch
);
    logic [N_CH-1:0] evt;
    logic [CH_W-1:0] first_idx;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        hpm_lane #(
            .DATA_W    (DATA_W),
            .CNT_W     (CNT_W),
            .MAX_STALL (MAX_STALL)
        ) u_lane (
            .CLK         (CLK),
            .RESET       (RESET),
            .enable      (enable),
            .clr_err     (clr_err),
            .valid       (valid[g]),
            .ready       (ready[g]),
            .data        (data[g*DATA_W +: DATA_W]),
            .count       (xfer_count[g*CNT_W +: CNT_W]),
            .err_drop    (err_drop[g]),
            .err_data    (err_data[g]),
            .err_timeout (err_timeout[g]),
            .evt_any     (evt[g])
        );

`ifdef HANDSHAKE_MONITOR_ASSERT_EN
        a_valid_hold: assert property (@(posedge CLK) disable iff (RESET || !enable)
            (valid[g] && !ready[g]) |=> valid[g]);
        a_data_stable: assert property (@(posedge CLK) disable iff (RESET || !enable)
            (valid[g] && !ready[g]) |=> $stable(data[g*DATA_W +: DATA_W]));
        a_no_timeout: assert property (@(posedge CLK) disable iff (RESET || !enable)
            not ((valid[g] && !ready[g]) [*MAX_STALL]));
`endif
    end

    // Priority pick: scan from the top down so the lowest erroring index wins.
    always_comb begin
        first_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (evt[i])
                first_idx = CH_W'(i);
    end

    assign err_any = |{err_drop, err_data, err_timeout};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            first_err_vld <= 1'b0;
            first_err_ch  <= '0;
        end else if ((|evt) && (!first_err_vld || clr_err)) begin
            first_err_vld <= 1'b1;
            first_err_ch  <= first_idx;
        end else if (clr_err) begin
            first_err_vld <= 1'b0;
            first_err_ch  <= '0;
        end
    end
endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Bench for handshake_protocol_monitor. It uses 3 channels, 4-bit data, a
// 4-bit counter so wrap is reachable, and MAX_STALL=4. Each scenario task
// keeps hand-derived expectations of the full output state. It pushes the
// expected snapshot when it drives a cycle, then pops and compares it one
// cycle later.
module tb_handshake_protocol_monitor;
    localparam int N_CH = 3, DATA_W = 4, CNT_W = 4, MAX_STALL = 4;

    logic                   CLK = 1'b0;
    logic                   RESET, enable, clr_err;
    logic [N_CH-1:0]        valid, ready;
    logic [N_CH*DATA_W-1:0] data;
    logic [N_CH*CNT_W-1:0]  xfer_count;
    logic [N_CH-1:0]        err_drop, err_data, err_timeout;
    logic                   err_any, first_err_vld;
    logic [1:0]             first_err_ch;

    handshake_protocol_monitor #(
        .N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)
    ) dut (
        .CLK(CLK), .RESET(RESET), .enable(enable), .clr_err(clr_err),
        .valid(valid), .ready(ready), .data(data),
        .xfer_count(xfer_count), .err_drop(err_drop), .err_data(err_data),
        .err_timeout(err_timeout), .err_any(err_any),
        .first_err_vld(first_err_vld), .first_err_ch(first_err_ch)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [11:0] cnt;
        logic [2:0]  drop, dat, to;
        logic        any, fv;
        logic [1:0]  fch;
    } snap_t;

    logic [3:0] e_cnt [3];
    logic [2:0] e_drop, e_dat, e_to;
    logic       e_fv;
    logic [1:0] e_fch;
    snap_t      sb [$];
    snap_t      got, want;
    int         n_cmp = 0, n_bad = 0;

    function automatic snap_t exp_snap();
        snap_t s;
        s.cnt  = {e_cnt[2], e_cnt[1], e_cnt[0]};
        s.drop = e_drop; s.dat = e_dat; s.to = e_to;
        s.any  = |{e_drop, e_dat, e_to};
        s.fv   = e_fv;   s.fch = e_fch;
        return s;
    endfunction

    function automatic snap_t obs_snap();
        snap_t s;
        s.cnt  = xfer_count;
        s.drop = err_drop; s.dat = err_data; s.to = err_timeout;
        s.any  = err_any;  s.fv = first_err_vld; s.fch = first_err_ch;
        return s;
    endfunction

    task automatic clear_exp_errs();
        e_drop = '0; e_dat = '0; e_to = '0; e_fv = 1'b0; e_fch = '0;
    endtask

    task automatic idle_inputs();
        RESET = 1'b0; enable = 1'b1; clr_err = 1'b0;
        valid = '0; ready = '0;
    endtask

    task automatic test_reset();
        RESET = 1'b1; enable = 1'b1; clr_err = 1'b1;
        valid = 3'b111; ready = 3'b010; data = 12'hABC;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) e_cnt[c] = '0;
            clear_exp_errs();
            sb.push_back(exp_snap());
            @(posedge CLK); #1;
            got = obs_snap(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL reset c%0d: got %h want %h", k, got, want); end
        end
        idle_inputs();
        sb.push_back(exp_snap());
        @(posedge CLK); #1;
        got = obs_snap(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL reset_release: got %h want %h", got, want); end
    endtask

    task automatic test_xfer();
        valid[0] = 1'b1; ready[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data[3:0] = 4'(k);
            e_cnt[0] = e_cnt[0] + 4'd1;
            sb.push_back(exp_snap());
            @(posedge CLK); #1;
            got = obs_snap(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL xfer c%0d: got %h want %h", k, got, want); end
        end
        idle_inputs();
        sb.push_back(exp_snap());
        @(posedge CLK); #1;
        got = obs_snap(); want = sb.pop_front(); n_cmp++;
        if (got !== want || xfer_count[3:0] !== 4'd5) begin
            n_bad++; $display("FAIL xfer_hold: got %h want %h (cnt0 %0d want 5)", got, want, xfer_count[3:0]);
        end
    endtask

    task automatic test_drop();
        valid[1] = 1'b1; ready[1] = 1'b0; data[7:4] = 4'h6;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                valid[1] = 1'b0;
                e_drop[1] = 1'b1; e_fv = 1'b1; e_fch = 2'd1;
            end
            sb.push_back(exp_snap());
            @(posedge CLK); #1;
            got = obs_snap(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL drop c%0d: got %h want %h", k, got, want); end
        end
        idle_inputs();
    endtask

    task automatic test_data();
        clr_err = 1'b1; clear_exp_errs();
        sb.push_back(exp_snap());
        @(posedge CLK); #1;
        got = obs_snap(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL data_clr: got %h want %h", got, want); end
        clr_err = 1'b0;
        valid[2] = 1'b1; ready[2] = 1'b0; data[11:8] = 4'h3;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin data[11:8] = 4'h5; e_dat[2] = 1'b1; e_fv = 1'b1; e_fch = 2'd2; end
            if (k == 2) begin ready[2] = 1'b1; e_cnt[2] = e_cnt[2] + 4'd1; end
            if (k == 3) idle_inputs();
            sb.push_back(exp_snap());
            @(posedge CLK); #1;
            got = obs_snap(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL data c%0d: got %h want %h", k, got, want); end
        end
    endtask

    task automatic test_timeout();
        clr_err = 1'b1; clear_exp_errs();
        sb.push_back(exp_snap());
        @(posedge CLK); #1;
        got = obs_snap(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL to_clr: got %h want %h", got, want); end
        clr_err = 1'b0;
        valid[0] = 1'b1; ready[0] = 1'b0; data[3:0] = 4'h9;
        // Stalled edges 1..5, then a transfer.
        for (int s = 1; s <= 6; s++) begin
            if (s == 4) begin e_to[0] = 1'b1; e_fv = 1'b1; e_fch = 2'd0; end
            if (s == 6) begin ready[0] = 1'b1; e_cnt[0] = e_cnt[0] + 4'd1; end
            sb.push_back(exp_snap());
            @(posedge CLK); #1;
            got = obs_snap(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL timeout s%0d: got %h want %h", s, got, want); end
        end
        idle_inputs();
    endtask

    task automatic test_enable();
        clr_err = 1'b1; clear_exp_errs();
        for (int k = 0; k < 4; k++) begin
            case (k)
                1: begin clr_err = 1'b0; valid[0] = 1'b1; ready[0] = 1'b0; end
                2: begin enable = 1'b0; valid[0] = 1'b0; end
                3: begin valid[0] = 1'b1; ready[0] = 1'b1; end
                default: ;
            endcase
            sb.push_back(exp_snap());
            @(posedge CLK); #1;
            got = obs_snap(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL enable c%0d: got %h want %h", k, got, want); end
        end
        // Re-enabled from a fresh IDLE: dropping valid now is not an error.
        idle_inputs();
        sb.push_back(exp_snap());
        @(posedge CLK); #1;
        got = obs_snap(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL reenable: got %h want %h", got, want); end
    endtask

    task automatic test_wrap();
        RESET = 1'b1;
        for (int c = 0; c < 3; c++) e_cnt[c] = '0;
        clear_exp_errs();
        sb.push_back(exp_snap());
        @(posedge CLK); #1;
        got = obs_snap(); want = sb.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL wrap_rst: got %h want %h", got, want); end
        idle_inputs();
        valid[0] = 1'b1; ready[0] = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            e_cnt[0] = 4'(k % 16);
            sb.push_back(exp_snap());
            @(posedge CLK); #1;
            got = obs_snap(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL wrap x%0d: got %h want %h", k, got, want); end
        end
        idle_inputs();
    endtask

    task automatic test_simul();
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin valid[0] = 1'b1; ready[0] = 1'b0; end
                1: begin
                    valid = 3'b110; ready = '0; data[11:8] = 4'h0;
                    e_drop[0] = 1'b1; e_fv = 1'b1; e_fch = 2'd0;
                end
                2: begin
                    valid = 3'b100; data[11:8] = 4'h7; clr_err = 1'b1;
                    e_drop = 3'b010; e_dat = 3'b100; e_to = '0; e_fv = 1'b1; e_fch = 2'd1;
                end
                3: begin
                    ready[2] = 1'b1; data[11:8] = 4'h0;
                    e_cnt[2] = e_cnt[2] + 4'd1; clear_exp_errs();
                end
                default: idle_inputs();
            endcase
            sb.push_back(exp_snap());
            @(posedge CLK); #1;
            got = obs_snap(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL simul c%0d: got %h want %h", k, got, want); end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin valid[0] = 1'b1; ready[0] = 1'b0; end
                1: begin
                    RESET = 1'b1;
                    for (int c = 0; c < 3; c++) e_cnt[c] = '0;
                    clear_exp_errs();
                end
                default: idle_inputs();
            endcase
            sb.push_back(exp_snap());
            @(posedge CLK); #1;
            got = obs_snap(); want = sb.pop_front(); n_cmp++;
            if (got !== want) begin n_bad++; $display("FAIL reset_mid c%0d: got %h want %h", k, got, want); end
        end
    endtask

    initial begin
        idle_inputs();
        data = '0;
        for (int c = 0; c < 3; c++) e_cnt[c] = '0;
        clear_exp_errs();
        #2;
        test_reset();
        test_xfer();
        test_drop();
        test_data();
        test_timeout();
        test_enable();
        test_wrap();
        test_simul();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
